phy_dly_sequencer: RTL

- Stores IDELAY/ODELAY tap values for up to NUM_LANES DDR3 byte lanes in an internal table.
- On command, streams the values into the lanes over the shared byte-lane delay bus (dly_data/dly_addr, one ld_delay per lane), then issues one shared set pulse.
- Sits between the software-accessible PHY control registers and the byte lanes.
- Removes per-delay bus sequencing from software and guarantees every delay is loaded before the common set.

---
 rtl/phy_dly_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/phy_dly_sequencer.sv
// phy_dly_sequencer
//   Holds IDELAY/ODELAY tap values for NUM_LANES DDR3 byte lanes and, on
//   start, streams them over the shared lane delay bus. Each entry gets one
//   ld_delay strobe for its lane. After SET_GAP idle cycles, one shared set
//   pulse follows.
//
// Ports
//   clk_div   : clock, rising edge
//   rst       : asynchronous active-high reset (the table is not cleared)
//   wr_en     : table write strobe
//   wr_addr   : {lane, dir, idx[3:0]}; dir=0 output delays, dir=1 input delays
//   wr_data   : tap value, [7:3] coarse, [2:0] fine
//   start     : begin a load sequence (single-cycle pulse)
//   lane_mask : lanes to load, sampled with start
//   busy      : sequence in progress
//   done      : one-cycle pulse at sequence end
//   wr_rej    : one-cycle pulse after a dropped write
//   dly_data  : delay value to the lanes
//   dly_addr  : {dir, idx[3:0]} to the lanes
//   ld_delay  : per-lane load strobe
//   set       : shared set-all-delays pulse
module phy_dly_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int LANE_BITS = 1,
  parameter int SET_GAP   = 2
) (
  input  logic                   clk_div,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [LANE_BITS+4:0]   wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   start,
  input  logic [NUM_LANES-1:0]   lane_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_rej,
  output logic [7:0]             dly_data,
  output logic [4:0]             dly_addr,
  output logic [NUM_LANES-1:0]   ld_delay,
  output logic                   set
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_GAP, ST_SET, ST_DONE} state_t;

  localparam int TBL_DEPTH = NUM_LANES * 32;

  logic [7:0] tbl [TBL_DEPTH];

  state_t                 state_q, state_n;
  logic [LANE_BITS-1:0]   lane_q, lane_n;
  logic                   dir_q, dir_n;
  logic [3:0]             idx_q, idx_n;
  logic [NUM_LANES-1:0]   mask_q, mask_n;
  logic [3:0]             gap_q, gap_n;
  logic [LANE_BITS:0]     hit;
  logic [NUM_LANES-1:0]   ld_n;
  logic [LANE_BITS+4:0]   rd_addr;

  logic [LANE_BITS-1:0]   wr_lane;
  logic                   wr_dir;
  logic [3:0]             wr_idx;
  logic                   wr_ok;
  logic                   wr_acc;

  // Returns {found, lane} for the lowest set mask bit at or above 'from'.
  function automatic logic [LANE_BITS:0] first_lane(input logic [NUM_LANES-1:0] m,
                                                     input int from);
    logic [LANE_BITS:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, LANE_BITS'(i)};
    end
    return r;
  endfunction

  assign wr_lane = wr_addr[LANE_BITS+4:5];
  assign wr_dir  = wr_addr[4];
  assign wr_idx  = wr_addr[3:0];
  // Output side has DM at idx 9; the input side stops at DQS (idx 8).
  assign wr_ok   = (32'(wr_lane) < NUM_LANES) && (wr_idx <= (wr_dir ? 4'd8 : 4'd9));
  assign wr_acc  = wr_en && !busy && wr_ok;

  // Table storage has no reset so delays survive a PHY reset.
  always_ff @(posedge clk_div) begin
    if (wr_acc) tbl[wr_addr] <= wr_data;
  end

  always_comb begin
    state_n = state_q;
    lane_n  = lane_q;
    dir_n   = dir_q;
    idx_n   = idx_q;
    mask_n  = mask_q;
    gap_n   = gap_q;
    hit     = '0;
    case (state_q)
      // DONE accepts a new start just like IDLE since busy is already low.
      ST_IDLE, ST_DONE: begin
        state_n = ST_IDLE;
        if (start) begin
          mask_n = lane_mask;
          hit    = first_lane(lane_mask, 0);
          if (hit[LANE_BITS]) begin
            state_n = ST_LOAD;
            lane_n  = hit[LANE_BITS-1:0];
            dir_n   = 1'b0;
            idx_n   = 4'd0;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (dir_q && idx_q == 4'd8) begin
          hit = first_lane(mask_q, int'(lane_q) + 1);
          if (hit[LANE_BITS]) begin
            lane_n = hit[LANE_BITS-1:0];
            dir_n  = 1'b0;
            idx_n  = 4'd0;
          end else begin
            state_n = ST_GAP;
            gap_n   = 4'd0;
          end
        end else if (!dir_q && idx_q == 4'd9) begin
          dir_n = 1'b1;
          idx_n = 4'd0;
        end else begin
          idx_n = idx_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'(SET_GAP - 1)) state_n = ST_SET;
        else                          gap_n   = gap_q + 4'd1;
      end
      ST_SET:  state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase

    ld_n = '0;
    if (state_n == ST_LOAD) ld_n[lane_n] = 1'b1;
  end

  assign rd_addr = {lane_n, dir_n, idx_n};

  // Outputs are registered from the next-state view so they line up with
  // the state they describe.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      dir_q    <= 1'b0;
      idx_q    <= 4'd0;
      mask_q   <= '0;
      gap_q    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_rej   <= 1'b0;
      set      <= 1'b0;
      ld_delay <= '0;
      dly_data <= 8'd0;
      dly_addr <= 5'd0;
    end else begin
      state_q  <= state_n;
      lane_q   <= lane_n;
      dir_q    <= dir_n;
      idx_q    <= idx_n;
      mask_q   <= mask_n;
      gap_q    <= gap_n;
      busy     <= (state_n == ST_LOAD) || (state_n == ST_GAP) || (state_n == ST_SET);
      done     <= (state_n == ST_DONE);
      set      <= (state_n == ST_SET);
      wr_rej   <= wr_en && (busy || !wr_ok);
      ld_delay <= ld_n;
      if (state_n == ST_LOAD) begin
        dly_data <= tbl[rd_addr];
        dly_addr <= {dir_n, idx_n};
      end
    end
  end

endmodule
